// File: rtl/stim_drv_pkg.sv
// Shared types and default sizes for the stimulus driver.
// STIM_DRV_GAP_EN adds the GAP state used for idle gaps between transfers.
package stim_drv_pkg;

  localparam int unsigned STIM_DATA_W = 32;
  localparam int unsigned STIM_DEPTH  = 8;
  localparam int unsigned STIM_CNT_W  = 16;
  localparam int unsigned STIM_GAP_W  = 4;

`ifdef STIM_DRV_GAP_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } stim_drv_state_t;
`else
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } stim_drv_state_t;
`endif

endpackage

// File: rtl/stim_driver_if.sv
// Push-side and DUT-side handshakes of the stimulus driver.
// gap_cycles exists only when STIM_DRV_GAP_EN is defined.
interface stim_driver_if
  import stim_drv_pkg::*;
#(
  parameter int unsigned DATA_W = STIM_DATA_W
`ifdef STIM_DRV_GAP_EN
  ,
  parameter int unsigned GAP_W  = STIM_GAP_W
`endif
);

  logic              push_valid;
  logic              push_ready;
  logic [DATA_W-1:0] push_data;
  logic              dut_valid;
  logic              dut_ready;
  logic [DATA_W-1:0] dut_data;
`ifdef STIM_DRV_GAP_EN
  logic [GAP_W-1:0]  gap_cycles;
`endif

  modport master (
    input  push_valid,
    input  push_data,
    input  dut_ready,
`ifdef STIM_DRV_GAP_EN
    input  gap_cycles,
`endif
    output push_ready,
    output dut_valid,
    output dut_data
  );

  modport slave (
    output push_valid,
    output push_data,
    output dut_ready,
`ifdef STIM_DRV_GAP_EN
    output gap_cycles,
`endif
    input  push_ready,
    input  dut_valid,
    input  dut_data
  );

endinterface

// File: rtl/stim_fifo.sv
// Circular word buffer with occupancy count; flush empties it and wins over push/pop.
module stim_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [LVL_W-1:0]  level_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q;
  logic              do_push, do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  assign do_push = push_i & ~full_o & ~flush_i & ~rst_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/stim_driver.sv
// Pops buffered stimulus words and holds each on the DUT handshake until accepted.
// STIM_DRV_GAP_EN enables idle gaps of gap_cycles after each transfer.
module stim_driver
  import stim_drv_pkg::*;
#(
  parameter int unsigned DATA_W = STIM_DATA_W,
  parameter int unsigned DEPTH  = STIM_DEPTH,
`ifdef STIM_DRV_GAP_EN
  parameter int unsigned GAP_W  = STIM_GAP_W,
`endif
  parameter int unsigned CNT_W  = STIM_CNT_W
) (
  input  logic                       tb_clk,
  input  logic                       tb_rst,
  input  logic                       flush,
  stim_driver_if.master              bus,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [CNT_W-1:0]           sent_count,
  output logic                       busy
);

  stim_drv_state_t   state_q, state_d;
  logic              dut_valid_q, dut_valid_d;
  logic [DATA_W-1:0] dut_data_q, dut_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifdef STIM_DRV_GAP_EN
  logic [GAP_W-1:0]  gap_q, gap_d;
`endif

  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [DATA_W-1:0] fifo_head;

  assign bus.push_ready = ~fifo_full;
  assign fifo_push      = bus.push_valid & ~fifo_full & ~flush;

  stim_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i   (tb_clk),
    .rst_i   (tb_rst),
    .flush_i (flush),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (bus.push_data),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  always_comb begin
    state_d     = state_q;
    dut_valid_d = dut_valid_q;
    dut_data_d  = dut_data_q;
    cnt_d       = cnt_q;
    fifo_pop    = 1'b0;
`ifdef STIM_DRV_GAP_EN
    gap_d       = gap_q;
`endif
    if (flush) begin
      state_d     = IDLE;
      dut_valid_d = 1'b0;
`ifdef STIM_DRV_GAP_EN
      gap_d       = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            fifo_pop    = 1'b1;
            dut_valid_d = 1'b1;
            dut_data_d  = fifo_head;
            state_d     = DRIVE;
          end
        end
        DRIVE: begin
          if (bus.dut_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
`ifdef STIM_DRV_GAP_EN
            if (bus.gap_cycles != '0) begin
              gap_d       = bus.gap_cycles;
              dut_valid_d = 1'b0;
              state_d     = GAP;
            end else
`endif
            if (!fifo_empty) begin
              fifo_pop   = 1'b1;
              dut_data_d = fifo_head;
            end else begin
              dut_valid_d = 1'b0;
              state_d     = IDLE;
            end
          end
        end
`ifdef STIM_DRV_GAP_EN
        GAP: begin
          // The last gap cycle launches the next word itself so the gap is exactly N long.
          if (gap_q <= GAP_W'(1)) begin
            gap_d = '0;
            if (!fifo_empty) begin
              fifo_pop    = 1'b1;
              dut_valid_d = 1'b1;
              dut_data_d  = fifo_head;
              state_d     = DRIVE;
            end else begin
              state_d = IDLE;
            end
          end else begin
            gap_d = gap_q - GAP_W'(1);
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge tb_clk) begin
    if (tb_rst) begin
      state_q     <= IDLE;
      dut_valid_q <= 1'b0;
      dut_data_q  <= '0;
      cnt_q       <= '0;
`ifdef STIM_DRV_GAP_EN
      gap_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      dut_valid_q <= dut_valid_d;
      dut_data_q  <= dut_data_d;
      cnt_q       <= cnt_d;
`ifdef STIM_DRV_GAP_EN
      gap_q       <= gap_d;
`endif
    end
  end

  assign bus.dut_valid = dut_valid_q;
  assign bus.dut_data  = dut_data_q;
  assign sent_count    = cnt_q;
  assign busy          = (state_q != IDLE) | (level != '0);

endmodule
